// File: rtl/alu_muldiv.sv
// Execute-stage ALU with registered result and an optional
// iterative radix-2 multiply/divide unit behind valid/ready.
module alu_muldiv #(
  parameter int WIDTH  = 32,
  parameter int MULDIV = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         md_op;
  logic               accept, start_md;
  logic [WIDTH-1:0]   alu_res, md_res;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_sum, rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge, lt_s, lt_u;

  assign o_ready  = (state != BUSY);
  assign o_valid  = (state == DONE);
  assign o_busy   = (state == BUSY);
  assign accept   = i_valid && o_ready;
  assign start_md = accept && (MULDIV != 0)
                 && (i_op[3:2] == 2'b11);

  assign shamt = i_b[SW-1:0];
  assign lt_s  = $signed(i_a) < $signed(i_b);
  assign lt_u  = i_a < i_b;

  always_comb begin
    alu_res = '0;
    unique case (i_op)
      4'b0000: alu_res = i_a | i_b;
      4'b0001: alu_res = i_a & i_b;
      4'b0010: alu_res = i_a + i_b;
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      4'b0100: alu_res = i_a ^ i_b;
      4'b0101: alu_res = ~(i_a | i_b);
      4'b0110: alu_res = i_a + ~i_b + 1'b1;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      4'b1000: alu_res = i_a << shamt;
      4'b1001: alu_res = i_a >> shamt;
      4'b1010: alu_res = $signed(i_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // prod holds {acc, multiplier} for MUL, {rem, quotient} for DIV
  always_comb begin
    add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
             + (prod[0] ? {1'b0, opnd} : '0);
    rem_sh   = prod[2*WIDTH-1:WIDTH-1];
    div_ge   = rem_sh >= {1'b0, opnd};
    div_diff = rem_sh[WIDTH-1:0] - opnd;
    prod_nx  = prod;
    if (!md_op[1])
      prod_nx = {add_sum, prod[WIDTH-1:1]};
    else if (div_ge)
      prod_nx = {div_diff, prod[WIDTH-2:0], 1'b1};
    else
      prod_nx = {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    md_res = md_op[0] ? prod_nx[2*WIDTH-1:WIDTH]
                      : prod_nx[WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = start_md ? BUSY : DONE;
      BUSY: if (cnt == '0) state_nx = DONE;
      DONE: begin
        if (accept) state_nx = start_md ? BUSY : DONE;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_result <= '0;
      o_zero   <= 1'b1;
      cnt      <= '0;
      prod     <= '0;
      opnd     <= '0;
      md_op    <= '0;
    end else if (accept) begin
      if (start_md) begin
        cnt   <= SW'(WIDTH-1);
        md_op <= i_op[1:0];
        opnd  <= i_op[1] ? i_b : i_a;
        prod  <= {{WIDTH{1'b0}}, (i_op[1] ? i_a : i_b)};
      end else begin
        o_result <= alu_res;
        o_zero   <= ~|alu_res;
      end
    end else if (state == BUSY) begin
      prod <= prod_nx;
      cnt  <= cnt - 1'b1;
      if (cnt == '0) begin
        o_result <= md_res;
        o_zero   <= ~|md_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against a
// plain-arithmetic reference model.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         ready, ovalid, zero, busy;
  logic [W-1:0] result;
  logic         ready0, ovalid0, zero0, busy0;
  logic [W-1:0] result0;

  int total = 0;
  int bad = 0;
  bit busy0_seen = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .MULDIV(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid),
    .o_ready(ready), .i_op(op), .i_a(a), .i_b(b),
    .o_valid(ovalid), .o_result(result), .o_zero(zero),
    .o_busy(busy)
  );

  alu_muldiv #(.WIDTH(W), .MULDIV(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid),
    .o_ready(ready0), .i_op(op), .i_a(a), .i_b(b),
    .o_valid(ovalid0), .o_result(result0), .o_zero(zero0),
    .o_busy(busy0)
  );

  always @(negedge clk) if (busy0) busy0_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_op(
    input logic [3:0] o, input logic [W-1:0] x,
    input logic [W-1:0] y);
    logic [63:0] p;
    logic signed [W-1:0] sx;
    int unsigned sh;
    sh = y % W;
    sx = x;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      4'd0:  return x | y;
      4'd1:  return x & y;
      4'd2:  return x + y;
      4'd3:  return ($signed(x) < $signed(y)) ? 1 : 0;
      4'd4:  return x ^ y;
      4'd5:  return ~(x | y);
      4'd6:  return x - y;
      4'd7:  return (x < y) ? 1 : 0;
      4'd8:  return x << sh;
      4'd9:  return x >> sh;
      4'd10: return sx >>> sh;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
      4'd14: return (y == 0) ? '1 : x / y;
      4'd15: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1;
    op = 4'd2; a = 32'd5; b = 32'd6;
    repeat (2) @(negedge clk);
    total++;
    if (ovalid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b want=0", ovalid);
    end
    total++;
    if (result !== '0) begin
      bad++; $display("FAIL reset_result got=%h want=0", result);
    end
    total++;
    if (zero !== 1'b1) begin
      bad++; $display("FAIL reset_zero got=%0b want=1", zero);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got rdy=%0b busy=%0b want 1/0",
               ready, busy);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0]   qo[$];
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] exp;
    int n;
    qo = '{4'd2, 4'd6, 4'd3, 4'd7, 4'd10, 4'd8};
    qa = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
           32'h8000_0000, 32'h8000_0000, 32'h0000_0003};
    qb = '{32'd1, 32'd7, 32'd1, 32'd1, 32'd4, 32'h21};
    for (int i = 0; i < 40; i++) begin
      qo.push_back(4'($urandom_range(0, 11)));
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
    n = qo.size();
    exp = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (ovalid !== 1'b1 || result !== exp) begin
          bad++;
          $display("FAIL single_%0d op=%0d got v=%0b r=%h want v=1 r=%h",
                   i - 1, qo[i-1], ovalid, result, exp);
        end
        total++;
        if (zero !== (exp == 0)) begin
          bad++;
          $display("FAIL single_zero_%0d got=%0b want=%0b",
                   i - 1, zero, exp == 0);
        end
        total++;
        if (ovalid0 !== 1'b1 || result0 !== exp) begin
          bad++;
          $display("FAIL single0_%0d got v=%0b r=%h want v=1 r=%h",
                   i - 1, ovalid0, result0, exp);
        end
      end
      if (i < n) begin
        valid = 1'b1; op = qo[i]; a = qa[i]; b = qb[i];
        exp = ref_op(qo[i], qa[i], qb[i]);
      end else begin
        valid = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (ovalid !== 1'b0 || result !== exp) begin
      bad++;
      $display("FAIL single_hold got v=%0b r=%h want v=0 r=%h",
               ovalid, result, exp);
    end
  endtask

  task automatic test_reset_busy();
    bit seen;
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 32'd3; b = 32'd5;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rstbusy_pre got busy=%0b want=1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || ready !== 1'b1 || ovalid !== 1'b0) begin
      bad++;
      $display("FAIL rstbusy_idle got b=%0b r=%0b v=%0b want 0/1/0",
               busy, ready, ovalid);
    end
    total++;
    if (result !== '0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL rstbusy_clr got r=%h z=%0b want 0/1",
               result, zero);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ovalid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rstbusy_novalid got=1 want=0");
    end
  endtask

  task automatic do_md(input logic [3:0] opc,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [W-1:0] exp;
    int cyc;
    bit early;
    @(negedge clk);
    valid = 1'b1; op = opc; a = x; b = y;
    exp = ref_op(opc, x, y);
    @(negedge clk);
    valid = 1'b0;
    cyc = 1; early = 1'b0;
    while (!ovalid && cyc < 100) begin
      if (ready !== 1'b0 || busy !== 1'b1) early = 1'b1;
      a = $urandom; b = $urandom; op = 4'($urandom);
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != W + 1) begin
      bad++;
      $display("FAIL md_lat op=%0d got=%0d want=%0d", opc, cyc, W + 1);
    end
    total++;
    if (result !== exp || zero !== (exp == 0)) begin
      bad++;
      $display("FAIL md_res op=%0d a=%h b=%h got=%h z=%0b want=%h",
               opc, x, y, result, zero, exp);
    end
    total++;
    if (early !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL md_ready op=%0d got early=%0b busy=%0b want 0/0",
               opc, early, busy);
    end
  endtask

  task automatic test_muldiv();
    do_md(4'd12, 32'h0001_0000, 32'h0001_0000);
    do_md(4'd13, 32'h0001_0000, 32'h0001_0000);
    do_md(4'd14, 32'd100, 32'd7);
    do_md(4'd15, 32'd100, 32'd7);
    do_md(4'd14, $urandom, 32'd0);
    do_md(4'd15, 32'd9, 32'd0);
    for (int i = 0; i < 8; i++)
      do_md(4'(12 + $urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20)
                                        : $urandom);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int cyc;
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 32'h1234; b = 32'h5678;
    exp = ref_op(4'd12, 32'h1234, 32'h5678);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      a = $urandom; b = $urandom;
    end while (!ovalid && cyc < 100);
    total++;
    if (cyc != W + 1 || result !== exp) begin
      bad++;
      $display("FAIL hs_hold got cyc=%0d r=%h want cyc=%0d r=%h",
               cyc, result, W + 1, exp);
    end
    op = 4'd14; a = 32'd1000; b = 32'd10;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0 || ovalid !== 1'b0) begin
      bad++;
      $display("FAIL hs_nobubble got b=%0b r=%0b v=%0b want 1/0/0",
               busy, ready, ovalid);
    end
    cyc = 1;
    while (!ovalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != W + 1 || result !== 32'd100) begin
      bad++;
      $display("FAIL hs_div got cyc=%0d r=%h want cyc=%0d r=%h",
               cyc, result, W + 1, 32'd100);
    end
    valid = 1'b1; op = 4'd11; a = $urandom | 1; b = $urandom;
    @(negedge clk);
    total++;
    if (ovalid !== 1'b1 || result !== '0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL hs_reserved got v=%0b r=%h z=%0b want 1/0/1",
               ovalid, result, zero);
    end
    op = 4'd2; a = 32'd2; b = 32'd3;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (ovalid !== 1'b1 || result !== 32'd5) begin
      bad++;
      $display("FAIL hs_add got v=%0b r=%h want v=1 r=5",
               ovalid, result);
    end
    @(negedge clk);
    total++;
    if (ovalid !== 1'b0 || result !== 32'd5) begin
      bad++;
      $display("FAIL hs_hold2 got v=%0b r=%h want v=0 r=5",
               ovalid, result);
    end
  endtask

  task automatic test_nomd();
    int cyc;
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 32'd3; b = 32'd4;
    @(negedge clk);
    total++;
    if (ovalid0 !== 1'b1 || result0 !== '0 || zero0 !== 1'b1) begin
      bad++;
      $display("FAIL nomd_mul got v=%0b r=%h z=%0b want 1/0/1",
               ovalid0, result0, zero0);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL nomd_main got busy=%0b want=1", busy);
    end
    for (int i = 0; i < 8; i++) begin
      op = 4'(12 + $urandom_range(0, 3));
      a = $urandom | 1; b = $urandom | 1;
      @(negedge clk);
      total++;
      if (ovalid0 !== 1'b1 || result0 !== '0) begin
        bad++;
        $display("FAIL nomd_%0d got v=%0b r=%h want v=1 r=0",
                 i, ovalid0, result0);
      end
    end
    valid = 1'b0;
    cyc = 0;
    while (!ovalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (result !== 32'd12) begin
      bad++;
      $display("FAIL nomd_ref got=%h want=%h", result, 32'd12);
    end
    @(negedge clk);
    total++;
    if (busy0_seen !== 1'b0) begin
      bad++; $display("FAIL nomd_busy got=1 want=0");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_busy();
    test_muldiv();
    test_back_to_back();
    test_nomd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Next-generation datapath ALU, parametrised in width, with a 4-bit opcode.
Single-cycle logic, arithmetic, compare and shift ops have a registered result.
An optional iterative radix-2 multiply/divide unit takes WIDTH cycles per op.
Sits in the execute stage behind a valid/ready handshake so the controller can stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of 2)
MULDIV, 1, 1 = multiply/divide unit present; 0 = opcodes 1100-1111 behave as reserved

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset_n  in  1  synchronous, active-low reset
i_valid  in  1  operation request
o_ready  out  1  block can accept a request this cycle
i_op  in  4  opcode
i_a  in  WIDTH  operand A
i_b  in  WIDTH  operand B (shift amount = i_b[$clog2(WIDTH)-1:0])
o_valid  out  1  one-cycle pulse: o_result/o_zero newly valid
o_result  out  WIDTH  registered result
o_zero  out  1  registered, 1 when o_result == 0
o_busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (i_reset_n=0 at a clock edge): state IDLE, o_valid=0, o_result=0, o_zero=1, o_busy=0; counter and mul/div registers cleared. Applies mid-operation; the in-flight op is abandoned and produces no o_valid.
- Opcodes: 0000 OR, 0001 AND, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0101 NOR, 0110 SUB, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 reserved (result 0), 1100 MUL (low WIDTH bits), 1101 MULHU (high WIDTH bits, unsigned), 1110 DIVU, 1111 REMU.
- ADD/SUB wrap modulo 2^WIDTH. SUB = A + ~B + 1. SLT/SLTU produce 0 or 1, zero-extended.
- Shifts use only the low $clog2(WIDTH) bits of i_b. SRA replicates i_a[WIDTH-1].
- States: IDLE, BUSY, DONE.
- Accept = i_valid && o_ready. o_ready = 1 in IDLE and DONE, 0 in BUSY. Inputs are captured only on accept; i_valid is ignored in BUSY.
- Single-cycle op accepted in cycle N: o_result/o_zero are updated and o_valid=1 in cycle N+1 (state DONE). Back-to-back accepts give 1 result per cycle.
- Multi-cycle op accepted in cycle N: state BUSY, o_busy=1, counter loaded with WIDTH-1. One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, WIDTH steps in total. o_valid=1 and the result appear in cycle N+WIDTH+1 (DONE). o_busy falls in that same cycle.
- DONE: o_valid high for exactly one cycle, with no backpressure. Next state is IDLE, or DONE/BUSY if a new request is accepted in that cycle.
- o_result and o_zero hold their last value until the next completion. No accept means no o_valid.
- Divide by zero: DIVU result = all ones; REMU result = i_a. This takes the same WIDTH+1 latency as other divides.
- MUL/MULHU use a 2*WIDTH-bit product register. Operands are treated as unsigned; the MUL low half is sign-agnostic.
- MULDIV=0: opcodes 1100-1111 complete in 1 cycle with result 0, and BUSY is never entered.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with i_valid=1 -> o_valid=0, o_result=0, o_zero=1, o_ready=1; reset asserted during BUSY -> IDLE next edge, no o_valid.
- Single-cycle ops back-to-back (WIDTH=32): ADD 0xFFFFFFFF+1 -> 0x00000000, o_zero=1; SUB 5-7 -> 0xFFFFFFFE; SLT 0x80000000,1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SLL by i_b=0x21 -> shift by 1. One o_valid per cycle, each one cycle after its accept.
- MUL 0x0001_0000 * 0x0001_0000 -> MUL 0x00000000 (o_zero=1), MULHU 0x00000001; o_valid exactly 33 cycles after accept; o_ready=0 for cycles 1-32.
- DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF, REMU 9/0 -> 9.
- Handshake: i_valid held high through BUSY -> no second accept until DONE; accept in the DONE cycle starts the next op with no IDLE bubble; i_op=1011 -> result 0.
- MULDIV=0 build: MUL 3*4 -> result 0 after 1 cycle, o_busy never asserted.
